mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 98 +++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesting cores, the arbiter and a single-port BRAM.
// The arbiter takes the slave modport; the core/BRAM side takes the master modport.
interface mem_arbiter_if #(
  parameter int unsigned NUM_CORES        = 2,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_BITS     = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 14
);
  logic [NUM_CORES-1:0]              req_valid;
  logic [NUM_CORES-1:0]              req_write;
  logic [NUM_CORES*ADDRESS_BITS-1:0] req_address;
  logic [NUM_CORES*DATA_WIDTH-1:0]   req_data;
  logic [NUM_CORES-1:0]              req_ready;
  logic [NUM_CORES-1:0]              resp_valid;
  logic [DATA_WIDTH-1:0]             resp_data;
  logic [MEM_ADDRESS_BITS-1:0]       mem_address;
  logic                              mem_write_en;
  logic [DATA_WIDTH-1:0]             mem_write_data;
  logic [DATA_WIDTH-1:0]             mem_read_data;
  logic [NUM_CORES*16-1:0]           grant_count;

  modport master (
    output req_valid, req_write, req_address, req_data, mem_read_data,
    input  req_ready, resp_valid, resp_data, mem_address, mem_write_en, mem_write_data,
    input  grant_count
  );

  modport slave (
    input  req_valid, req_write, req_address, req_data, mem_read_data,
    output req_ready, resp_valid, resp_data, mem_address, mem_write_en, mem_write_data,
    output grant_count
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_CORES cores.
// Writes take one cycle; reads take two (grant, then data return).
module mem_arbiter #(
  parameter int unsigned NUM_CORES        = 2,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDRESS_BITS     = 32,
  parameter int unsigned MEM_ADDRESS_BITS = 14
) (
  input  logic            clock,
  input  logic            reset,
  mem_arbiter_if.slave    bus
);

  localparam int unsigned IdxW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [0:0] {StIdle, StReadWait} state_e;

  state_e          state_q;
  logic [IdxW-1:0] last_grant_q;
  logic [IdxW-1:0] winner_q;
  logic [15:0]     grant_count_q [NUM_CORES];

  logic            grant_found;
  logic [IdxW-1:0] grant_idx;
  logic            grant_write;
  logic            in_read_wait;
  logic            unused_addr;

  // Only the word-address bits of each request address are consumed.
  assign unused_addr  = ^bus.req_address;
  assign in_read_wait = !reset && (state_q == StReadWait);

  always_comb begin : pick
    logic [IdxW-1:0] cand;
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = last_grant_q;
    if (!reset && state_q == StIdle) begin
      for (int unsigned n = 0; n < NUM_CORES; n++) begin
        cand = (32'(cand) == NUM_CORES - 1) ? '0 : cand + 1'b1;
        if (!grant_found && bus.req_valid[cand]) begin
          grant_found = 1'b1;
          grant_idx   = cand;
        end
      end
    end
  end

  always_comb begin : drive
    bus.req_ready      = '0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    grant_write        = 1'b0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_found && 32'(grant_idx) == i) begin
        bus.req_ready[i]   = 1'b1;
        bus.mem_address    = bus.req_address[i*ADDRESS_BITS+2 +: MEM_ADDRESS_BITS];
        grant_write        = bus.req_write[i];
        bus.mem_write_data = bus.req_write[i] ? bus.req_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
      end
    end
    bus.mem_write_en = grant_write;
    bus.resp_valid   = in_read_wait ? (NUM_CORES'(1) << winner_q) : '0;
    bus.resp_data    = in_read_wait ? bus.mem_read_data : '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      bus.grant_count[i*16 +: 16] = grant_count_q[i];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      last_grant_q <= IdxW'(NUM_CORES - 1);
      winner_q     <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        grant_count_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (grant_found) begin
            last_grant_q <= grant_idx;
            if (grant_count_q[grant_idx] != 16'hFFFF) begin
              grant_count_q[grant_idx] <= grant_count_q[grant_idx] + 16'd1;
            end
            if (!grant_write) begin
              winner_q <= grant_idx;
              state_q  <= StReadWait;
            end
          end
        end
        StReadWait: state_q <= StIdle;
        default:    state_q <= StIdle;
      endcase
    end
  end

endmodule
